imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning program-counter width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning stored words, legal range 1..2^ADDR_W.
REQ-004 The block SHALL have parameter NOP_WORD, default all-zero, meaning the word returned for unmapped addresses.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning reset, asynchronous, active-high.
REQ-007 The block SHALL have port req_valid, input, 1 bit, meaning a fetch request is present.
REQ-008 The block SHALL have port req_addr, input, ADDR_W bits, meaning the fetch address (PC).
REQ-009 The block SHALL have port req_ready, output, 1 bit, meaning the block accepts a request this cycle.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit, meaning the queue head holds a fetched word.
REQ-011 The block SHALL have port rsp_data, output, DATA_W bits, meaning the fetched instruction.
REQ-012 The block SHALL have port rsp_addr, output, ADDR_W bits, meaning the address rsp_data came from.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit, meaning the consumer takes the head word.
REQ-014 The block SHALL have port flush, input, 1 bit, meaning discard all queued responses (taken jump/branch).
REQ-015 The block SHALL have port ld_en, input, 1 bit, meaning program-load write strobe.
REQ-016 The block SHALL have port ld_addr, input, ADDR_W bits, meaning program-load address.
REQ-017 The block SHALL have port ld_data, input, DATA_W bits, meaning program-load data.

Function
REQ-018 Storage SHALL be a DEPTH x DATA_W array written at the clock edge when ld_en=1 and ld_addr<DEPTH; writes with ld_addr>=DEPTH are dropped.
REQ-019 Response buffering SHALL be a 2-entry FIFO with occupancy count 0..2; rsp_valid=(count!=0); rsp_data/rsp_addr are the head entry.
REQ-020 req_ready SHALL be asserted when ld_en=0 and (count<2 or flush=1), with no combinational path from rsp_ready.
REQ-021 On accept (req_valid & req_ready), the array SHALL be read at that edge and {mem[req_addr], req_addr} pushed; req_addr>=DEPTH pushes NOP_WORD; latency is exactly 1 cycle to rsp_valid when the FIFO is empty.
REQ-022 Pop SHALL occur when rsp_valid & rsp_ready; simultaneous push and pop leaves count unchanged, sustaining one word per cycle.
REQ-023 While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_addr SHALL remain stable.
REQ-024 flush=1 SHALL empty the FIFO at that edge; a request accepted in the same cycle becomes the sole entry (count=1); pop is ignored that cycle.
REQ-025 ld_en=1 SHALL block acceptance; a fetch accepted after a load edge returns the newly written data (no stale read).
REQ-026 Queued entries SHALL NOT be altered by later loads to the same address.

Reset
REQ-027 rst=1 SHALL immediately set count=0, rsp_valid=0, rsp_data=NOP_WORD, rsp_addr=0, and req_ready=1 (if ld_en=0), including mid-transfer.
REQ-028 Array contents SHALL be unaffected by rst; power-up contents are NOP_WORD.

Structure
REQ-029 Default widths, DEPTH, and NOP_WORD SHALL reside in the shared processor package with the opcode definitions.
REQ-030 The 2-entry queue SHALL be the single sub-module fetch_skid_fifo; array and control logic remain in imem_fetch.

Verification
REQ-031 Load 0x47D2@0, 0xAF01@1, then fetch 0,1 back-to-back with rsp_ready=1 -> 0x47D2/addr0 then 0xAF01/addr1 on consecutive cycles.
REQ-032 Fetch 0,1,2 with rsp_ready=0 -> count reaches 2, req_ready=0, head 0x47D2 held stable; release rsp_ready -> drains in order.
REQ-033 Queue holds 2 entries; assert flush with request addr 5 -> next cycle count=1, rsp_addr=5.
REQ-034 DEPTH=8, fetch addr 9 -> rsp_data=NOP_WORD, rsp_addr=9; ld_en to addr 9 -> no array change.
REQ-035 Fetch outstanding, assert rst asynchronously mid-cycle -> rsp_valid falls before next edge; after release, first fetch has 1-cycle latency.
REQ-036 ld_en=1 with req_valid=1 -> req_ready=0; next cycle fetch same address -> new ld_data returned.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
//------------------------------------------------------------------------------
// imem_fetch_pkg : shared processor definitions (fetch defaults, opcodes)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package imem_fetch_pkg;

  localparam int unsigned IMEM_DATA_W = 16;
  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_DEPTH  = 256;
  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_WORD = '0;

  localparam int unsigned OPCODE_W = 4;

  // Opcode lives in the top nibble of an instruction word; all-zero decodes as NOP.
  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_JMP  = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BNE  = 4'hB,
    OP_CALL = 4'hC,
    OP_RET  = 4'hD,
    OP_IO   = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  function automatic opcode_e decode_opcode(input logic [IMEM_DATA_W-1:0] word);
    return opcode_e'(word[IMEM_DATA_W-1 -: OPCODE_W]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
//------------------------------------------------------------------------------
// fetch_skid_fifo : 2-entry response queue (head + tail) with flush
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_skid_fifo
  import imem_fetch_pkg::*;
#(
  parameter int unsigned         DATA_W   = IMEM_DATA_W,
  parameter int unsigned         ADDR_W   = IMEM_ADDR_W,
  parameter logic [DATA_W-1:0]   NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [1:0]        count_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [ADDR_W-1:0] head_addr_o
);

  logic [1:0]        count_q,     count_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic [ADDR_W-1:0] tail_addr_q, tail_addr_d;
  logic              do_pop;

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_addr_d = head_addr_q;
    tail_data_d = tail_data_q;
    tail_addr_d = tail_addr_q;
    do_pop      = pop_i && (count_q != 2'd0) && !flush_i;

    if (flush_i) begin
      // Flush wins over pop; a same-cycle push survives as the only entry.
      count_d = push_i ? 2'd1 : 2'd0;
      if (push_i) begin
        head_data_d = push_data_i;
        head_addr_d = push_addr_i;
      end
    end else begin
      unique case ({push_i, do_pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_data_d = push_data_i;
            head_addr_d = push_addr_i;
          end else if (count_q == 2'd1) begin
            tail_data_d = push_data_i;
            tail_addr_d = push_addr_i;
          end
          if (count_q != 2'd2) begin
            count_d = count_q + 2'd1;
          end
        end
        2'b01: begin
          head_data_d = tail_data_q;
          head_addr_d = tail_addr_q;
          count_d     = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_data_d = push_data_i;
            head_addr_d = push_addr_i;
          end else begin
            head_data_d = tail_data_q;
            head_addr_d = tail_addr_q;
            tail_data_d = push_data_i;
            tail_addr_d = push_addr_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= 2'd0;
      head_data_q <= NOP_WORD;
      head_addr_q <= '0;
      tail_data_q <= NOP_WORD;
      tail_addr_q <= '0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_addr_q <= head_addr_d;
      tail_data_q <= tail_data_d;
      tail_addr_q <= tail_addr_d;
    end
  end

  assign count_o     = count_q;
  assign valid_o     = (count_q != 2'd0);
  assign head_data_o = head_data_q;
  assign head_addr_o = head_addr_q;

endmodule

`default_nettype wire

// File: rtl/imem_fetch.sv
//------------------------------------------------------------------------------
// imem_fetch : loadable instruction memory with 1-cycle fetch and response queue
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module imem_fetch
  import imem_fetch_pkg::*;
#(
  parameter int unsigned       DATA_W   = IMEM_DATA_W,
  parameter int unsigned       ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned       DEPTH    = IMEM_DEPTH,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              rsp_ready,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W+1)'(DEPTH);

  // Storage is deliberately outside the reset domain; it powers up as NOP.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

  logic              ld_hit;
  logic              req_in_range;
  logic              accept;
  logic              pop;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        count;

  assign ld_hit       = ld_en && ({1'b0, ld_addr} < DEPTH_CMP);
  assign req_in_range = ({1'b0, req_addr} < DEPTH_CMP);
  assign rd_word      = req_in_range ? mem_q[req_addr[IDX_W-1:0]] : NOP_WORD;

  // Loads and fetches never share an edge, so a fetch always sees completed writes.
  assign req_ready = !ld_en && ((count != 2'd2) || flush);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (ld_hit) begin
      mem_q[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end

  fetch_skid_fifo #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NOP_WORD (NOP_WORD)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_data_i (rd_word),
    .push_addr_i (req_addr),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (count),
    .valid_o     (rsp_valid),
    .head_data_o (rsp_data),
    .head_addr_o (rsp_addr)
  );

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch.sv
//------------------------------------------------------------------------------
// tb_imem_fetch : directed scoreboard bench for imem_fetch (DEPTH=8)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_fetch;

  localparam int          DW    = 16;
  localparam int          AW    = 8;
  localparam int          DEPTH = 8;
  localparam logic [15:0] NOP   = 16'h0000;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_ready;
  logic          flush;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  imem_fetch #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_ready (rsp_ready),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]    model_mem [DEPTH];
  logic [DW+AW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic tick(input string tag);
    logic             ready_m;
    logic [DW-1:0]    word;
    @(negedge clk);
    ready_m = !ld_en && ((sb.size() < 2) || flush);
    chk({tag, ":req_ready"}, 32'(req_ready), 32'(ready_m));
    chk({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk({tag, ":rsp_data"}, 32'(rsp_data), 32'(sb[0][DW+AW-1:AW]));
      chk({tag, ":rsp_addr"}, 32'(rsp_addr), 32'(sb[0][AW-1:0]));
    end
    if (flush) sb.delete();
    else if ((sb.size() != 0) && rsp_ready) void'(sb.pop_front());
    if (ld_en && (int'(ld_addr) < DEPTH)) model_mem[ld_addr[2:0]] = ld_data;
    if (req_valid && ready_m) begin
      word = (int'(req_addr) < DEPTH) ? model_mem[req_addr[2:0]] : NOP;
      sb.push_back({word, req_addr});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;

    #2;
    chk("reset:rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset:rsp_data",  32'(rsp_data),  32'(NOP));
    chk("reset:rsp_addr",  32'(rsp_addr),  32'h0);
    chk("reset:req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Program load; a pending request must be refused while ld_en is high
    ld_en = 1'b1; ld_addr = 8'd0; ld_data = 16'h47D2; req_valid = 1'b1; req_addr = 8'd0;
    tick("load0");
    ld_addr = 8'd1; ld_data = 16'hAF01; tick("load1");
    ld_addr = 8'd5; ld_data = 16'h1234; req_valid = 1'b0; tick("load5");
    ld_en = 1'b0;

    // Back-to-back fetch, one word per cycle
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 8'd0; tick("b2b0");
    chk("b2b0:lat_valid", 32'(rsp_valid), 32'h1);
    chk("b2b0:lat_data",  32'(rsp_data),  32'h47D2);
    req_addr = 8'd1; tick("b2b1");
    chk("b2b1:data", 32'(rsp_data), 32'hAF01);
    chk("b2b1:addr", 32'(rsp_addr), 32'h1);
    req_valid = 1'b0; tick("b2b_drain"); tick("b2b_idle");

    // Fill with consumer stalled, then release
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd0; tick("fill0");
    req_addr = 8'd1; tick("fill1");
    req_addr = 8'd2; tick("full_a"); tick("full_b");
    chk("full:head_stable", 32'(rsp_data), 32'h47D2);
    chk("full:req_ready",   32'(req_ready), 32'h0);
    rsp_ready = 1'b1; tick("rel0"); tick("rel1");
    req_valid = 1'b0; tick("rel2"); tick("rel3");

    // Flush with two queued plus a same-cycle request; pop is ignored
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd0; tick("pfl0");
    req_addr = 8'd1; tick("pfl1");
    flush = 1'b1; req_addr = 8'd5; rsp_ready = 1'b1; tick("flush");
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    chk("flush:valid", 32'(rsp_valid), 32'h1);
    chk("flush:addr",  32'(rsp_addr),  32'h5);
    chk("flush:data",  32'(rsp_data),  32'h1234);
    tick("post_flush");
    rsp_ready = 1'b1; tick("flush_drain"); tick("flush_idle");

    // Out-of-range fetch and dropped out-of-range load
    req_valid = 1'b1; req_addr = 8'd9; tick("oor_fetch");
    chk("oor:data", 32'(rsp_data), 32'(NOP));
    chk("oor:addr", 32'(rsp_addr), 32'h9);
    req_valid = 1'b0; ld_en = 1'b1; ld_addr = 8'd9; ld_data = 16'hBEEF; tick("oor_load");
    ld_en = 1'b0; req_valid = 1'b1; req_addr = 8'd1; tick("alias_fetch");
    chk("alias:data", 32'(rsp_data), 32'hAF01);
    req_valid = 1'b0; tick("alias_idle");

    // Load blocks a request; the next-cycle fetch sees the new data
    ld_en = 1'b1; ld_addr = 8'd3; ld_data = 16'h5A5A; req_valid = 1'b1; req_addr = 8'd3;
    tick("ld_block");
    ld_en = 1'b0; tick("ld_fetch");
    chk("ld_fetch:data", 32'(rsp_data), 32'h5A5A);
    req_valid = 1'b0; tick("ld_idle");

    // A queued word is not altered by a later load to its address
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd0; tick("hold_fetch");
    req_valid = 1'b0; ld_en = 1'b1; ld_addr = 8'd0; ld_data = 16'h9999; tick("hold_load");
    ld_en = 1'b0;
    chk("hold:data", 32'(rsp_data), 32'h47D2);
    rsp_ready = 1'b1; tick("hold_pop"); tick("hold_idle");

    // Asynchronous reset with a word outstanding
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd1; tick("pre_rst");
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst:rsp_valid", 32'(rsp_valid), 32'h0);
    chk("async_rst:rsp_data",  32'(rsp_data),  32'(NOP));
    chk("async_rst:rsp_addr",  32'(rsp_addr),  32'h0);
    chk("async_rst:req_ready", 32'(req_ready), 32'h1);
    sb.delete();
    tick("in_rst");
    rst = 1'b0; req_valid = 1'b1; req_addr = 8'd1; rsp_ready = 1'b1; tick("post_rst");
    chk("post_rst:valid", 32'(rsp_valid), 32'h1);
    chk("post_rst:data",  32'(rsp_data),  32'hAF01);
    req_valid = 1'b0; tick("post_rst_drain"); tick("post_rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
